// File: rtl/store_merge_unit.sv
// Store sequencer for a 64-bit data memory: sd writes directly, sw/sh/sb do read-merge-write; busy holds off new requests.
// Latency start->done: sd 2 cycles, sw/sh/sb MEM_RD_LAT+2 cycles. Optional build macro: MISALIGN_TRAP_EN.
module store_merge_unit #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  tam,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_RD_LAT - 1);

    localparam logic [1:0] TAM_SD = 2'b00;
    localparam logic [1:0] TAM_SW = 2'b01;
    localparam logic [1:0] TAM_SH = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_DN   = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_tam;
    logic [2:0]       r_lane;
    logic [63:0]      r_wdata;
    logic [63:0]      r_mem_addr;
    logic [63:0]      r_mem_wdata;
    logic             r_mis;
    logic             w_accept;
    logic             w_mis;
    logic             w_rd_last;

    // Replace only the addressed lane of the read doubleword; everything else passes through.
    function automatic logic [63:0] f_merge(
        input logic [63:0] old_dw,
        input logic [1:0]  size,
        input logic [2:0]  lane,
        input logic [63:0] dat
    );
        logic [63:0] res;
        res = old_dw;
        case (size)
            TAM_SW:  res[{lane[2],   5'd0} +: 32] = dat[31:0];
            TAM_SH:  res[{lane[2:1], 4'd0} +: 16] = dat[15:0];
            default: res[{lane[2:0], 3'd0} +: 8]  = dat[7:0];
        endcase
        return res;
    endfunction

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        w_mis = 1'b0;
        case (tam)
            TAM_SD:  w_mis = (addr[2:0] != 3'b000);
            TAM_SW:  w_mis = (addr[1:0] != 2'b00);
            TAM_SH:  w_mis = addr[0];
            default: w_mis = 1'b0;
        endcase
    end
`else
    assign w_mis = 1'b0;
`endif

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_rd_last = (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A trapped store still spends the WR slot (with the strobe suppressed) so it keeps sd timing.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = ((tam == TAM_SD) || w_mis) ? S_WR : S_RD;
                end
            end
            S_RD:    if (w_rd_last) w_state_nxt = S_WR;
            S_WR:    w_state_nxt = S_DN;
            S_DN:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_tam       <= 2'b00;
            r_lane      <= 3'b000;
            r_wdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mis       <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= CNT_INIT;
            r_tam      <= tam;
            r_lane     <= addr[2:0];
            r_wdata    <= wdata;
            r_mem_addr <= {addr[63:3], 3'b000};
            r_mis      <= w_mis;
            if (tam == TAM_SD) begin
                r_mem_wdata <= wdata;
            end
        end else if (r_state == S_RD) begin
            if (w_rd_last) begin
                r_mem_wdata <= f_merge(mem_rdata, r_tam, r_lane, r_wdata);
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = (r_state == S_WR) && !r_mis;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DN);

`ifdef MISALIGN_TRAP_EN
    assign err = (r_state == S_DN) && r_mis;
`else
    assign err = 1'b0;
`endif

endmodule
